// File: rtl/biu_datapath_pkg.sv
// Shared definitions for the BIU address/data path: status and address-select codes,
// config word layout and the burst-code-to-length table.
package biu_datapath_pkg;

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_CONT  = 2'd1,
      ST_IDLE  = 2'd2,
      ST_BUSY  = 2'd3
   } status_e;

   typedef enum logic {
      XFER_READ  = 1'b0,
      XFER_WRITE = 1'b1
   } xfer_e;

   typedef enum logic [1:0] {
      ASEL_ROW  = 2'b00,
      ASEL_COL  = 2'b01,
      ASEL_MODE = 2'b10,
      ASEL_PRE  = 2'b11
   } addr_sel_e;

   localparam logic [31:0] PROG_ADDR_DEF = 32'h3FFF_FFFF;
   localparam logic [2:0]  BURST_FULL    = 3'd7;
   localparam int          SD_A10        = 10;

   // Config word as written by the master in program mode.
   typedef struct packed {
      logic [7:0] tcas;
      logic [7:0] twait;
      logic [7:0] tpre;
      logic [3:0] tlat;
      logic       addr_mode;   // 0 sequential, 1 interleaved
      logic [2:0] burst;
   } cfg_t;

   // Code 7 is a full page, i.e. every column of the open row.
   function automatic int unsigned burst_len(input logic [2:0] code, input int unsigned col_w);
      return (code == BURST_FULL) ? (32'd1 << col_w) : (32'd1 << code);
   endfunction

endpackage

// File: rtl/biu_col_counter.sv
// Per-beat column generator: start column, beat count, sequential/interleaved wrap
// inside the burst window, and the end-of-burst pulse.
module biu_col_counter
   import biu_datapath_pkg::*;
#(
   parameter int COL_W = 10
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             En,
   input  logic             load,
   input  logic [COL_W-1:0] start_col,
   input  logic             beat,
   input  logic             addr_mode,
   input  logic [2:0]       burst,
   output logic [COL_W-1:0] col,
   output logic             burst_done
);

   logic [COL_W-1:0] start_q, cnt_q, col_q;
   logic [COL_W-1:0] mask, cnt_nxt, low_nxt, col_nxt;
   logic             full_page, done_q;

   // Only the low log2(BL) bits move; the bits above the burst window stay at start.
   always_comb begin
      full_page = (burst == BURST_FULL);
      mask      = COL_W'(burst_len(burst, COL_W) - 32'd1);
      cnt_nxt   = (cnt_q + COL_W'(1)) & mask;
      low_nxt   = (full_page || !addr_mode) ? (start_q + cnt_nxt) : (start_q ^ cnt_nxt);
      col_nxt   = (start_q & ~mask) | (low_nxt & mask);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         start_q <= '0;
         cnt_q   <= '0;
         col_q   <= '0;
         done_q  <= 1'b0;
      end else if (En) begin
         if (load) begin
            start_q <= start_col;
            cnt_q   <= '0;
            col_q   <= start_col;
            done_q  <= 1'b0;
         end else if (beat) begin
            cnt_q   <= cnt_nxt;
            col_q   <= col_nxt;
            done_q  <= (cnt_q == mask);
         end else begin
            done_q  <= 1'b0;
         end
      end
   end

   assign col        = col_q;
   assign burst_done = done_q;

endmodule

// File: rtl/biu_datapath.sv
// BIU address/data path: address and config latches, SDRAM address mux, write/read data
// registers. Optional per-byte parity when BIU_DP_PARITY_EN is defined.
module biu_datapath
   import biu_datapath_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter int          COL_W     = 10,
   parameter int          ROW_W     = 13,
   parameter int          BANK_W    = 2,
   parameter logic [31:0] PROG_ADDR = PROG_ADDR_DEF
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                En,
   input  logic [8:0]          Control,
   input  logic [31:0]         AddrIn,
   input  logic [DATA_W-1:0]   DataIn,
   input  logic                Ready,
   input  logic                StoreReg,
   input  logic                EnWdata,
   input  logic                EnRdata,
   input  logic [1:0]          AddrSel,
   input  logic [DATA_W-1:0]   DqIn,
   output logic [ROW_W-1:0]    SdAddr,
   output logic [BANK_W-1:0]   SdBa,
   output logic [DATA_W-1:0]   DqOut,
   output logic                DqOe,
   output logic [DATA_W-1:0]   RdData,
   output logic                RdValid,
`ifdef BIU_DP_PARITY_EN
   output logic [DATA_W/8-1:0] DqParOut,
   input  logic [DATA_W/8-1:0] DqParIn,
   output logic                ParErr,
`endif
   output logic                BurstDone
);

   localparam int NBYTES = DATA_W / 8;

   cfg_t              cfg_q;
   logic [BANK_W-1:0] bank_q;
   logic [ROW_W-1:0]  row_q;
   logic [COL_W-1:0]  col;
   logic [DATA_W-1:0] dq_out_q, rd_data_q;
   logic              dq_oe_q, rd_valid_q;
   logic              addr_load, beat;

   // The program-mode address only carries the config word; it must not disturb bank/row.
   assign addr_load = Ready && (Control[8:7] == ST_START) && (AddrIn != PROG_ADDR);
   assign beat      = EnWdata | EnRdata;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cfg_q      <= '0;
         bank_q     <= '0;
         row_q      <= '0;
         dq_out_q   <= '0;
         dq_oe_q    <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else if (En) begin
         if (StoreReg)
            cfg_q <= cfg_t'(DataIn[31:0]);
         if (addr_load) begin
            bank_q <= AddrIn[COL_W+ROW_W +: BANK_W];
            row_q  <= AddrIn[COL_W +: ROW_W];
         end
         dq_oe_q <= EnWdata;
         if (EnWdata)
            dq_out_q <= DataIn;
         rd_valid_q <= EnRdata;
         if (EnRdata)
            rd_data_q <= DqIn;
      end
   end

   biu_col_counter #(.COL_W(COL_W)) u_col (
      .Clk        (Clk),
      .Rst        (Rst),
      .En         (En),
      .load       (addr_load),
      .start_col  (AddrIn[COL_W-1:0]),
      .beat       (beat),
      .addr_mode  (cfg_q.addr_mode),
      .burst      (cfg_q.burst),
      .col        (col),
      .burst_done (BurstDone)
   );

   always_comb begin
      SdAddr = '0;
      case (AddrSel)
         ASEL_ROW:  SdAddr = row_q;
         ASEL_COL:  SdAddr = ROW_W'(col);
         ASEL_MODE: SdAddr = ROW_W'({cfg_q.tlat[2:0], cfg_q.addr_mode, cfg_q.burst});
         ASEL_PRE:  SdAddr = ROW_W'(1) << SD_A10;
         default:   SdAddr = '0;
      endcase
   end

   assign SdBa    = bank_q;
   assign DqOut   = dq_out_q;
   assign DqOe    = dq_oe_q;
   assign RdData  = rd_data_q;
   assign RdValid = rd_valid_q;

`ifdef BIU_DP_PARITY_EN
   logic [NBYTES-1:0] par_wr, par_rd;
   logic [NBYTES-1:0] par_out_q;
   logic              par_err_q;

   // Even parity: the stored bit makes each byte plus its parity bit an even count of ones.
   always_comb begin
      par_wr = '0;
      par_rd = '0;
      for (int b = 0; b < NBYTES; b++) begin
         par_wr[b] = ^DataIn[b*8 +: 8];
         par_rd[b] = ^DqIn[b*8 +: 8];
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         par_out_q <= '0;
         par_err_q <= 1'b0;
      end else if (En) begin
         if (EnWdata)
            par_out_q <= par_wr;
         par_err_q <= EnRdata && (par_rd != DqParIn);
      end
   end

   assign DqParOut = par_out_q;
   assign ParErr   = par_err_q;
`endif

   // Timing fields and the R/W bit are consumed by biu_controls, not here.
   logic unused_ok;
   assign unused_ok = ^{Control[6:0], cfg_q.tcas, cfg_q.twait, cfg_q.tpre, cfg_q.tlat[3], NBYTES[0]};

endmodule

// File: tb/tb_biu_datapath.sv
// Directed self-checking bench for biu_datapath; parity checks are built when
// BIU_DP_PARITY_EN is defined.
module tb_biu_datapath;

   localparam logic [1:0] S_START = 2'b00;
   localparam logic [1:0] S_CONT  = 2'b01;
   localparam logic [1:0] S_IDLE  = 2'b10;

   logic        Clk = 1'b0;
   logic        Rst, En, Ready, StoreReg, EnWdata, EnRdata;
   logic [8:0]  Control;
   logic [31:0] AddrIn, DataIn, DqIn;
   logic [1:0]  AddrSel;
   logic [12:0] SdAddr;
   logic [1:0]  SdBa;
   logic [31:0] DqOut, RdData;
   logic        DqOe, RdValid, BurstDone;
`ifdef BIU_DP_PARITY_EN
   logic [3:0]  DqParOut, DqParIn;
   logic        ParErr;
`endif

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   biu_datapath dut (
      .Clk(Clk), .Rst(Rst), .En(En), .Control(Control), .AddrIn(AddrIn), .DataIn(DataIn),
      .Ready(Ready), .StoreReg(StoreReg), .EnWdata(EnWdata), .EnRdata(EnRdata),
      .AddrSel(AddrSel), .DqIn(DqIn), .SdAddr(SdAddr), .SdBa(SdBa), .DqOut(DqOut),
      .DqOe(DqOe), .RdData(RdData), .RdValid(RdValid),
`ifdef BIU_DP_PARITY_EN
      .DqParOut(DqParOut), .DqParIn(DqParIn), .ParErr(ParErr),
`endif
      .BurstDone(BurstDone)
   );

   task automatic cyc;
      @(posedge Clk);
      #1;
   endtask

   task automatic load_cfg(input logic [31:0] w);
      StoreReg = 1'b1;
      DataIn   = w;
      cyc();
      StoreReg = 1'b0;
   endtask

   task automatic start_xfer(input logic [31:0] a);
      Ready   = 1'b1;
      Control = {S_START, 6'd0, 1'b1};
      AddrIn  = a;
      cyc();
      Ready   = 1'b0;
      Control = {S_CONT, 6'd0, 1'b1};
   endtask

   task automatic test_reset;
      Rst = 1'b0; En = 1'b1; Ready = 1'b0; StoreReg = 1'b0; EnWdata = 1'b0; EnRdata = 1'b0;
      Control = {S_IDLE, 7'd0}; AddrIn = '0; DataIn = '0; DqIn = '0; AddrSel = 2'b00;
`ifdef BIU_DP_PARITY_EN
      DqParIn = '0;
`endif
      #3;
      checks++;
      if ({DqOe, RdValid, BurstDone} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got %b exp 000", {DqOe, RdValid, BurstDone});
      end
      checks++;
      if (DqOut !== 32'h0 || RdData !== 32'h0 || SdBa !== 2'd0 || SdAddr !== 13'h0) begin
         errors++; $display("FAIL reset_regs dq %h rd %h ba %h addr %h exp all 0", DqOut, RdData, SdBa, SdAddr);
      end
      AddrSel = 2'b10;
      #1;
      checks++;
      if (SdAddr !== 13'h0) begin
         errors++; $display("FAIL reset_cfg got %h exp 0000", SdAddr);
      end
      cyc(); cyc();
      Rst = 1'b1;
      cyc();
   endtask

   // BL4 sequential, start 0xAB (config byte 0x32: CL 3, seq, code 2).
   task automatic test_seq_burst;
      logic [31:0] wd [4];
      logic [12:0] ec [4];
      wd = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
      ec = '{13'h0AB, 13'h0A8, 13'h0A9, 13'h0AA};
      load_cfg(32'h0503_0432);
      start_xfer({7'd0, 2'd2, 13'h1234, 10'h0AB});
      AddrSel = 2'b00;
      #1;
      checks++;
      if (SdAddr !== 13'h1234 || SdBa !== 2'd2) begin
         errors++; $display("FAIL seq_row got %h/%h exp 1234/2", SdAddr, SdBa);
      end
      AddrSel = 2'b01;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (SdAddr !== ec[i]) begin
            errors++; $display("FAIL seq_col%0d got %h exp %h", i, SdAddr, ec[i]);
         end
         EnWdata = 1'b1;
         DataIn  = wd[i];
         cyc();
         checks++;
         if (DqOut !== wd[i] || DqOe !== 1'b1 || BurstDone !== (i == 3)) begin
            errors++; $display("FAIL seq_beat%0d dq %h oe %b done %b exp %h 1 %b", i, DqOut, DqOe, BurstDone, wd[i], (i == 3));
         end
      end
      EnWdata = 1'b0;
      DataIn  = 32'hFFFF_FFFF;
      cyc();
      checks++;
      if (DqOe !== 1'b0 || BurstDone !== 1'b0 || DqOut !== wd[3] || SdAddr !== 13'h0AB) begin
         errors++; $display("FAIL seq_end oe %b done %b dq %h col %h exp 0 0 %h 0ab", DqOe, BurstDone, DqOut, SdAddr, wd[3]);
      end
   endtask

   // BL4 interleaved at 0xAD, using read beats; also checks the read return path.
   task automatic test_interleave_read;
      logic [12:0] ec [4];
      logic [31:0] rd [4];
      ec = '{13'h0AD, 13'h0AC, 13'h0AF, 13'h0AE};
      rd = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D};
      load_cfg(32'h0000_000A);
      start_xfer({7'd0, 2'd1, 13'h0042, 10'h0AD});
      AddrSel = 2'b01;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (SdAddr !== ec[i]) begin
            errors++; $display("FAIL il_col%0d got %h exp %h", i, SdAddr, ec[i]);
         end
         EnRdata = 1'b1;
         DqIn    = rd[i];
         cyc();
         checks++;
         if (RdData !== rd[i] || RdValid !== 1'b1 || BurstDone !== (i == 3) || DqOe !== 1'b0) begin
            errors++; $display("FAIL il_rd%0d data %h v %b done %b oe %b exp %h 1 %b 0", i, RdData, RdValid, BurstDone, DqOe, rd[i], (i == 3));
         end
      end
      EnRdata = 1'b0;
      DqIn    = 32'h0;
      cyc();
      checks++;
      if (RdValid !== 1'b0 || RdData !== 32'hCAFE_F00D) begin
         errors++; $display("FAIL il_rd_end v %b data %h exp 0 cafef00d", RdValid, RdData);
      end
   endtask

   task automatic test_mode_regs;
      load_cfg(32'h0000_00F3);
      AddrSel = 2'b10;
      #1;
      checks++;
      if (SdAddr !== 13'h073) begin
         errors++; $display("FAIL mode_reg got %h exp 0073", SdAddr);
      end
      AddrSel = 2'b11;
      #1;
      checks++;
      if (SdAddr !== 13'h0400) begin
         errors++; $display("FAIL precharge got %h exp 0400", SdAddr);
      end
   endtask

   // Full-page wrap at the top column, and BL1 ending on every beat.
   task automatic test_boundaries;
      load_cfg(32'h0000_0007);
      start_xfer({7'd0, 2'd3, 13'h0001, 10'h3FE});
      AddrSel = 2'b01;
      EnWdata = 1'b1;
      cyc();
      checks++;
      if (SdAddr !== 13'h3FF || BurstDone !== 1'b0) begin
         errors++; $display("FAIL fp_b1 col %h done %b exp 3ff 0", SdAddr, BurstDone);
      end
      cyc();
      checks++;
      if (SdAddr !== 13'h000 || BurstDone !== 1'b0) begin
         errors++; $display("FAIL fp_wrap col %h done %b exp 000 0", SdAddr, BurstDone);
      end
      EnWdata = 1'b0;
      load_cfg(32'h0000_0000);
      start_xfer({7'd0, 2'd0, 13'h0002, 10'h055});
      EnWdata = 1'b1;
      cyc();
      EnWdata = 1'b0;
      checks++;
      if (SdAddr !== 13'h055 || BurstDone !== 1'b1) begin
         errors++; $display("FAIL bl1 col %h done %b exp 055 1", SdAddr, BurstDone);
      end
      cyc();
      checks++;
      if (BurstDone !== 1'b0) begin
         errors++; $display("FAIL bl1_pulse done %b exp 0", BurstDone);
      end
   endtask

   // En hold, START beating a coincident beat, program-mode and non-START addresses ignored.
   task automatic test_priority_hold;
      load_cfg(32'h0000_0002);
      start_xfer({7'd0, 2'd1, 13'h0100, 10'h100});
      AddrSel = 2'b01;
      EnWdata = 1'b1;
      DataIn  = 32'h5555_AAAA;
      cyc();
      En      = 1'b0;
      DataIn  = 32'h0BAD_0BAD;
      cyc(); cyc();
      checks++;
      if (SdAddr !== 13'h101 || DqOut !== 32'h5555_AAAA || DqOe !== 1'b1) begin
         errors++; $display("FAIL en_hold col %h dq %h oe %b exp 101 5555aaaa 1", SdAddr, DqOut, DqOe);
      end
      En = 1'b1;
      start_xfer({7'd0, 2'd2, 13'h0ABC, 10'h202});
      EnWdata = 1'b0;
      checks++;
      if (SdAddr !== 13'h202 || SdBa !== 2'd2) begin
         errors++; $display("FAIL start_wins col %h ba %h exp 202 2", SdAddr, SdBa);
      end
      start_xfer(32'h3FFF_FFFF);
      Ready   = 1'b1;
      Control = {S_IDLE, 7'd0};
      AddrIn  = {7'd0, 2'd0, 13'h1FFF, 10'h3FF};
      cyc();
      Ready   = 1'b0;
      AddrSel = 2'b00;
      #1;
      checks++;
      if (SdAddr !== 13'h0ABC || SdBa !== 2'd2) begin
         errors++; $display("FAIL no_latch row %h ba %h exp 0abc 2", SdAddr, SdBa);
      end
   endtask

   task automatic test_reset_mid;
      load_cfg(32'h0000_0003);
      start_xfer({7'd0, 2'd3, 13'h0777, 10'h010});
      AddrSel = 2'b01;
      EnWdata = 1'b1;
      DataIn  = 32'h7777_7777;
      EnRdata = 1'b0;
      cyc(); cyc(); cyc();
      checks++;
      if (SdAddr !== 13'h013) begin
         errors++; $display("FAIL mid_col got %h exp 013", SdAddr);
      end
      Rst = 1'b0;
      #1;
      checks++;
      if (DqOe !== 1'b0 || DqOut !== 32'h0 || SdAddr !== 13'h0 || SdBa !== 2'd0 || BurstDone !== 1'b0) begin
         errors++; $display("FAIL mid_rst oe %b dq %h col %h ba %h done %b exp all 0", DqOe, DqOut, SdAddr, SdBa, BurstDone);
      end
      for (int i = 0; i < 6; i++) begin
         cyc();
         checks++;
         if (BurstDone !== 1'b0 || DqOe !== 1'b0) begin
            errors++; $display("FAIL mid_rst_hold%0d done %b oe %b exp 0 0", i, BurstDone, DqOe);
         end
      end
      EnWdata = 1'b0;
      Rst     = 1'b1;
      cyc();
   endtask

`ifdef BIU_DP_PARITY_EN
   task automatic test_parity;
      EnWdata = 1'b1;
      DataIn  = 32'hDEAD_BEEF;
      cyc();
      EnWdata = 1'b0;
      checks++;
      if (DqParOut !== 4'b0101) begin
         errors++; $display("FAIL par_out got %b exp 0101", DqParOut);
      end
      EnRdata = 1'b1;
      DqIn    = 32'hDEAD_BEEF;
      DqParIn = 4'b0101;
      cyc();
      checks++;
      if (ParErr !== 1'b0 || RdValid !== 1'b1) begin
         errors++; $display("FAIL par_ok err %b v %b exp 0 1", ParErr, RdValid);
      end
      DqParIn = 4'b0100;
      cyc();
      EnRdata = 1'b0;
      checks++;
      if (ParErr !== 1'b1) begin
         errors++; $display("FAIL par_err got %b exp 1", ParErr);
      end
      cyc();
      checks++;
      if (ParErr !== 1'b0) begin
         errors++; $display("FAIL par_pulse got %b exp 0", ParErr);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_seq_burst();
      test_interleave_read();
      test_mode_regs();
      test_boundaries();
      test_priority_hold();
      test_reset_mid();
`ifdef BIU_DP_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
